// File: rtl/coeff_bank_pkg.sv
// coeff_bank_pkg
// Shared definitions for the coefficient-bank selector:
//   - Avalon word offsets of the CTRL/STATUS register and the first SHADOW register
//   - bit positions inside the CTRL/STATUS read word
//   - register-kind enum used by the address decoder
//   - clog2 helper used for elaboration-time parameter checks
package coeff_bank_pkg;

  localparam int CTRL        = 0;
  localparam int SHADOW_BASE = 1;

  localparam int PENDING    = 0;
  localparam int FADING     = 1;
  localparam int WEIGHT_LSB = 16;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_SHADOW,
    REG_NONE
  } reg_kind_e;

  // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/coeff_fade_ramp.sv
// coeff_fade_ramp
// Linear crossfade ramp. A start pulse zeroes the weight and begins a fade;
// every tick during the fade advances the weight by one, and the fade ends on
// the tick that brings the weight to FADE_LEN. Idle state holds the weight at
// FADE_LEN so the downstream blend sees the new bank at full weight.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   start        - begin a new fade (only asserted while not fading)
//   tick         - one-cycle sample strobe
//   fade_weight  - weight of the new bank, 0..FADE_LEN (registered)
//   fading       - fade in progress (registered)
module coeff_fade_ramp #(
  parameter int FADE_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  output logic [7:0] fade_weight,
  output logic       fading
);

  localparam logic [7:0] LAST_WEIGHT = 8'(FADE_LEN);

  logic [7:0] next_weight;

  assign next_weight = fade_weight + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      fade_weight <= LAST_WEIGHT;
      fading      <= 1'b0;
    end else if (start) begin
      fade_weight <= 8'd0;
      fading      <= 1'b1;
    end else if (fading && tick) begin
      fade_weight <= next_weight;
      // The tick that reaches full weight also ends the fade at the same edge.
      if (next_weight == LAST_WEIGHT) begin
        fading <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coeff_bank_sel.sv
// coeff_bank_sel
// Coefficient-bank selector with Avalon-MM shadow registers. Software loads a
// shadow bank index per channel and arms a commit; on the next sample tick
// outside a crossfade, all channels switch at once and a linear crossfade
// ramp starts so the FIR stage can blend old and new banks.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   address       - Avalon word address (0 = CTRL/STATUS, 1..NUM_CH = SHADOW)
//   chipselect    - Avalon select
//   write_n       - Avalon write strobe, active-low
//   writedata     - Avalon write data
//   readdata      - Avalon read data, combinational, zero-wait
//   sample_tick   - one-cycle strobe per audio sample
//   bank_active   - current bank per channel, channel c at [c*BANK_W +: BANK_W]
//   bank_prev     - banks in effect before the last commit
//   fade_weight   - weight of the new bank, 0..FADE_LEN
//   fading        - crossfade in progress
//   commit_pulse  - one-cycle pulse after each commit
module coeff_bank_sel
  import coeff_bank_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int BANK_W   = 2,
  parameter int FADE_LEN = 64,
  parameter int ADDR_W   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     sample_tick,
  output logic [NUM_CH*BANK_W-1:0] bank_active,
  output logic [NUM_CH*BANK_W-1:0] bank_prev,
  output logic [7:0]               fade_weight,
  output logic                     fading,
  output logic                     commit_pulse
);

  if (NUM_CH < 1 || NUM_CH > 7 || BANK_W < 1 || BANK_W > 8 ||
      FADE_LEN < 1 || FADE_LEN > 255 || ADDR_W < clog2(NUM_CH + 1)) begin : g_param_error
    $error("coeff_bank_sel: illegal parameter combination");
  end

  logic [BANK_W-1:0]        shadow [NUM_CH];
  logic [NUM_CH*BANK_W-1:0] shadow_flat;
  logic                     pending;
  logic                     wr;
  logic                     arm;
  logic                     commit;
  reg_kind_e                reg_kind;
  logic [2:0]               ch_sel;
  logic                     unused_wdata;

  assign unused_wdata = ^writedata[31:BANK_W];

  // Address decode: which register the current Avalon address points at.
  always_comb begin
    reg_kind = REG_NONE;
    ch_sel   = 3'd0;
    if (address == ADDR_W'(CTRL)) begin
      reg_kind = REG_CTRL;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == ADDR_W'(c + SHADOW_BASE)) begin
        reg_kind = REG_SHADOW;
        ch_sel   = 3'(c);
      end
    end
  end

  assign wr     = chipselect && !write_n;
  assign arm    = wr && (reg_kind == REG_CTRL) && writedata[0];
  assign commit = sample_tick && pending && !fading;

  always_comb begin
    shadow_flat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_flat[c*BANK_W +: BANK_W] = shadow[c];
    end
  end

  // Register file, pending flag and the committed bank state. The commit
  // copies the registered shadows, so a shadow write in the commit cycle
  // lands after the snapshot and waits for the next commit. An arm write in
  // the commit cycle re-arms pending for a further commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= 1'b0;
      bank_active  <= '0;
      bank_prev    <= '0;
      commit_pulse <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= '0;
      end
    end else begin
      commit_pulse <= commit;
      pending      <= arm || (pending && !commit);
      if (commit) begin
        bank_prev   <= bank_active;
        bank_active <= shadow_flat;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr && reg_kind == REG_SHADOW && ch_sel == 3'(c)) begin
          shadow[c] <= writedata[BANK_W-1:0];
        end
      end
    end
  end

  coeff_fade_ramp #(
    .FADE_LEN(FADE_LEN)
  ) u_ramp (
    .clk        (clk),
    .reset      (reset),
    .start      (commit),
    .tick       (sample_tick),
    .fade_weight(fade_weight),
    .fading     (fading)
  );

  // Zero-wait read mux; unmapped addresses read as zero.
  always_comb begin
    readdata = '0;
    case (reg_kind)
      REG_CTRL: begin
        readdata[PENDING]             = pending;
        readdata[FADING]              = fading;
        readdata[WEIGHT_LSB +: 8]     = fade_weight;
      end
      REG_SHADOW: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel == 3'(c)) begin
            readdata[BANK_W-1:0]      = shadow[c];
            readdata[16 +: BANK_W]    = bank_active[c*BANK_W +: BANK_W];
          end
        end
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_coeff_bank_sel.sv
// tb_coeff_bank_sel
// Directed bench for coeff_bank_sel with NUM_CH=2, BANK_W=2, FADE_LEN=64.
// Each expected commit is queued when its tick is issued; a monitor checks
// bank and ramp state whenever commit_pulse is seen.
module tb_coeff_bank_sel;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sample_tick;
  logic [3:0]  bank_active;
  logic [3:0]  bank_prev;
  logic [7:0]  fade_weight;
  logic        fading;
  logic        commit_pulse;

  typedef struct packed {
    logic [3:0] active;
    logic [3:0] prev;
    logic [7:0] weight;
    logic       fading;
  } exp_t;

  exp_t sb [$];
  int   total_checks = 0;
  int   bad_checks   = 0;

  coeff_bank_sel #(
    .NUM_CH  (2),
    .BANK_W  (2),
    .FADE_LEN(64),
    .ADDR_W  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .sample_tick (sample_tick),
    .bank_active (bank_active),
    .bank_prev   (bank_prev),
    .fade_weight (fade_weight),
    .fading      (fading),
    .commit_pulse(commit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every commit_pulse must match the oldest queued commit.
  always @(negedge clk) begin
    if (commit_pulse === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL unexpected_commit: got commit_pulse=1 expected none (active=0x%0h)", bank_active);
      end else begin
        e = sb.pop_front();
        checkOutput("commit_active", 32'(bank_active), 32'(e.active));
        checkOutput("commit_prev",   32'(bank_prev),   32'(e.prev));
        checkOutput("commit_weight", 32'(fade_weight), 32'(e.weight));
        checkOutput("commit_fading", 32'(fading),      32'(e.fading));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with optional sample_tick; any bus write already set up by the
  // caller happens in the same cycle. An expected commit is queued first.
  task automatic applyStimulus(input logic do_tick, input logic exp_commit,
                               input logic [3:0] exp_active, input logic [3:0] exp_prev);
    exp_t e;
    if (exp_commit) begin
      e.active = exp_active;
      e.prev   = exp_prev;
      e.weight = 8'd0;
      e.fading = 1'b1;
      sb.push_back(e);
    end
    sample_tick = do_tick;
    step();
    sample_tick = 1'b0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
  endtask

  task automatic set_write(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
  endtask

  task automatic av_write(input logic [2:0] addr, input logic [31:0] data);
    set_write(addr, data);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic check_read(input string name, input logic [2:0] addr, input logic [31:0] expected);
    address    = addr;
    chipselect = 1'b1;
    #1;
    checkOutput(name, readdata, expected);
    chipselect = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    address     = 3'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'd0;
    sample_tick = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_active", 32'(bank_active), 32'h0);
    checkOutput("rst_prev",   32'(bank_prev),   32'h0);
    checkOutput("rst_weight", 32'(fade_weight), 32'd64);
    checkOutput("rst_fading", 32'(fading),      32'h0);
    checkOutput("rst_pulse",  32'(commit_pulse), 32'h0);
    check_read("rst_status", 3'd0, 32'h0040_0000);

    // Unmapped address write is ignored and reads zero
    av_write(3'd7, 32'hFFFF_FFFF);
    check_read("unmapped_read", 3'd7, 32'h0);
    check_read("unmapped_status", 3'd0, 32'h0040_0000);
    check_read("unmapped_shadow0", 3'd1, 32'h0);
    check_read("unmapped_shadow1", 3'd2, 32'h0);

    // Basic commit
    av_write(3'd1, 32'h2);
    av_write(3'd2, 32'h3);
    check_read("shadow0_read", 3'd1, 32'h0000_0002);
    av_write(3'd0, 32'h1);
    check_read("armed_status", 3'd0, 32'h0040_0001);
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b0000);
    checkOutput("basic_pulse", 32'(commit_pulse), 32'h1);
    step();
    checkOutput("basic_pulse_once", 32'(commit_pulse), 32'h0);
    check_read("fading_status", 3'd0, 32'h0000_0002);
    check_read("shadow0_active", 3'd1, 32'h0002_0002);
    idle_ticks(63);
    checkOutput("basic_w63", 32'(fade_weight), 32'd63);
    checkOutput("basic_f63", 32'(fading), 32'h1);
    idle_ticks(1);
    checkOutput("basic_w64", 32'(fade_weight), 32'd64);
    checkOutput("basic_f64", 32'(fading), 32'h0);

    // Commit with shadow equal to active still runs a full fade
    av_write(3'd0, 32'h1);
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b1110);
    idle_ticks(10);
    checkOutput("refade_w10", 32'(fade_weight), 32'd10);

    // Arm while fading: commit waits for the tick after the fade ends
    av_write(3'd1, 32'h1);
    av_write(3'd0, 32'h1);
    check_read("arm_fading_status", 3'd0, 32'h000A_0003);
    idle_ticks(54);
    checkOutput("fade_end_w", 32'(fade_weight), 32'd64);
    checkOutput("fade_end_f", 32'(fading), 32'h0);
    checkOutput("fade_end_no_pulse", 32'(commit_pulse), 32'h0);
    check_read("still_pending", 3'd0, 32'h0040_0001);
    applyStimulus(1'b1, 1'b1, 4'b1101, 4'b1110);
    idle_ticks(64);
    checkOutput("second_fade_w", 32'(fade_weight), 32'd64);

    // Same-cycle arm and tick: no commit until the following tick
    set_write(3'd0, 32'h1);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("same_cycle_no_pulse", 32'(commit_pulse), 32'h0);
    check_read("same_cycle_pending", 3'd0, 32'h0040_0001);
    // Shadow write in the commit cycle is not part of this commit
    set_write(3'd1, 32'h2);
    applyStimulus(1'b1, 1'b1, 4'b1101, 4'b1101);
    check_read("late_shadow", 3'd1, 32'h0001_0002);
    idle_ticks(20);
    checkOutput("pre_reset_w", 32'(fade_weight), 32'd20);

    // Mid-fade reset with pending set and a simultaneous tick
    av_write(3'd0, 32'h1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    reset = 1'b0;
    checkOutput("mreset_active", 32'(bank_active), 32'h0);
    checkOutput("mreset_prev",   32'(bank_prev),   32'h0);
    checkOutput("mreset_weight", 32'(fade_weight), 32'd64);
    checkOutput("mreset_fading", 32'(fading),      32'h0);
    check_read("mreset_status", 3'd0, 32'h0040_0000);
    check_read("mreset_shadow0", 3'd1, 32'h0);
    idle_ticks(1);
    checkOutput("mreset_no_commit", 32'(commit_pulse), 32'h0);

    step();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
